turtle_core: RTL and testbench

Parametrised multi-cycle successor to the 16-bit TurtleMCU CPU top. It executes a fixed 16-bit instruction format over a DATA_W-wide datapath with an external synchronous memory port. Input and output ports use full valid/ready handshakes with backpressure, and the core has an explicit HALT state. It sits between the system RAM wrapper and the board-level I/O.

---
 rtl/turtle_pkg.sv | 74 +++++++
 rtl/turtle_alu.sv | 63 ++++++
 rtl/turtle_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_turtle_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turtle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : turtle_pkg
// Purpose  : Shared types and constants for the TurtleMCU multi-cycle core:
//            opcode, FSM-state and ALU-op enums, instruction field
//            positions and the parameter legality helper.
// Ports    : none (package)
// Options  : TURTLE_SHIFT_EN (consumed by turtle_core, not by this package)
// Revision : 1.0 - initial release
// ============================================================================
package turtle_pkg;

  // Legal parameter ranges
  localparam int c_DATA_W_MIN = 16;
  localparam int c_DATA_W_MAX = 32;
  localparam int c_ADDR_W_MIN = 8;
  localparam int c_ADDR_W_MAX = 12;

  // Instruction word and field positions
  localparam int c_INSN_W = 16;
  localparam int c_OP_HI  = 15;
  localparam int c_OP_LO  = 12;
  localparam int c_RA_HI  = 11;
  localparam int c_RA_LO  = 9;
  localparam int c_RB_HI  = 8;
  localparam int c_RB_LO  = 6;
  localparam int c_IMM_HI = 7;
  localparam int c_IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_XOR  = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JC   = 4'hA,
    OP_IN   = 4'hB,
    OP_OUT  = 4'hC,
    OP_SHL  = 4'hD,
    OP_SHR  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_IN_WAIT  = 3'd4,
    S_OUT_WAIT = 3'd5,
    S_HALT     = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SHL = 3'd4,
    ALU_SHR = 3'd5
  } alu_op_e;

  function automatic bit turtle_params_ok(input int data_w, input int addr_w);
    return (data_w >= c_DATA_W_MIN) && (data_w <= c_DATA_W_MAX) &&
           (addr_w >= c_ADDR_W_MIN) && (addr_w <= c_ADDR_W_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/turtle_alu.sv
`default_nettype none
// ============================================================================
// Module   : turtle_alu
// Purpose  : Combinational ALU for turtle_core.
// Ports    : op     in  alu_op_e  operation select
//            a      in  DATA_W    first operand (ra)
//            b      in  DATA_W    second operand (rb)
//            result out DATA_W    operation result
//            carry  out 1         carry (ADD), borrow (SUB), shifted-out
//                                 bit (SHL/SHR), 0 for AND/XOR
//            zero   out 1         result is all zeros
// Revision : 1.0 - initial release
// ============================================================================
module turtle_alu
  import turtle_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  // One extra bit so the carry/borrow falls out of bit DATA_W directly
  logic [DATA_W:0] w_wide;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    w_wide = '0;
    case (op)
      ALU_ADD: begin
        w_wide = {1'b0, a} + {1'b0, b};
        result = w_wide[DATA_W-1:0];
        carry  = w_wide[DATA_W];
      end
      ALU_SUB: begin
        // Underflow wraps into bit DATA_W, which is exactly the borrow
        w_wide = {1'b0, a} - {1'b0, b};
        result = w_wide[DATA_W-1:0];
        carry  = w_wide[DATA_W];
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/turtle_core.sv
`default_nettype none
// ============================================================================
// Module   : turtle_core
// Purpose  : Multi-cycle TurtleMCU CPU. Fixed 16-bit instructions over a
//            DATA_W datapath, synchronous external memory, valid/ready
//            input and output ports, explicit HALT state.
// Ports    : clk        in  1       system clock
//            rst        in  1       synchronous active-high reset
//            mem_addr   out ADDR_W  memory address
//            mem_we     out 1       write strobe (EXEC of ST only)
//            mem_wdata  out DATA_W  write data
//            mem_rdata  in  DATA_W  read data, one cycle after mem_addr
//            in_data    in  DATA_W  input port data
//            in_valid   in  1       input data available
//            in_ready   out 1       core consumes in_data (IN_WAIT only)
//            out_data   out DATA_W  output data, stable while out_valid
//            out_valid  out 1       output data pending (registered)
//            out_ready  in  1       sink accepts
//            halted     out 1       core is in HALT
// Options  : TURTLE_SHIFT_EN - enables SHL (0xD) / SHR (0xE); when
//            undefined those opcodes behave as NOP.
// Revision : 1.0 - initial release
// ============================================================================
module turtle_core
  import turtle_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  if (!turtle_params_ok(DATA_W, ADDR_W)) begin : g_bad_params
    $error("turtle_core: DATA_W must be 16..32 and ADDR_W 8..12");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [c_INSN_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]     regs_q [8];
  logic [DATA_W-1:0]     regs_d [8];
  logic                  c_q, c_d;
  logic                  z_q, z_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  opcode_e               w_op;
  logic [2:0]            w_ra;
  logic [2:0]            w_rb;
  logic [7:0]            w_imm8;
  logic [ADDR_W-1:0]     w_jaddr;
  logic [DATA_W-1:0]     w_ra_val;
  logic [DATA_W-1:0]     w_rb_val;
  alu_op_e               w_alu_op;
  logic [DATA_W-1:0]     w_alu_res;
  logic                  w_alu_c;
  logic                  w_alu_z;

  assign w_op     = opcode_e'(ir_q[c_OP_HI:c_OP_LO]);
  assign w_ra     = ir_q[c_RA_HI:c_RA_LO];
  assign w_rb     = ir_q[c_RB_HI:c_RB_LO];
  assign w_imm8   = ir_q[c_IMM_HI:c_IMM_LO];
  assign w_jaddr  = ir_q[ADDR_W-1:0];
  // Operands are read from the current register state, so ra==rb uses
  // the old value even though ra is the destination.
  assign w_ra_val = regs_q[w_ra];
  assign w_rb_val = regs_q[w_rb];

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_op)
      OP_SUB:  w_alu_op = ALU_SUB;
      OP_AND:  w_alu_op = ALU_AND;
      OP_XOR:  w_alu_op = ALU_XOR;
      OP_SHL:  w_alu_op = ALU_SHL;
      OP_SHR:  w_alu_op = ALU_SHR;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  turtle_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (w_alu_op),
    .a      (w_ra_val),
    .b      (w_rb_val),
    .result (w_alu_res),
    .carry  (w_alu_c),
    .zero   (w_alu_z)
  );

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mem_addr    = pc_q;
    mem_we      = 1'b0;
    mem_wdata   = '0;

    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        ir_d    = mem_rdata[c_INSN_W-1:0];
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (w_op)
          OP_LDI: regs_d[w_ra] = {{(DATA_W-8){1'b0}}, w_imm8};
          OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            regs_d[w_ra] = w_alu_res;
            c_d          = w_alu_c;
            z_d          = w_alu_z;
          end
`ifdef TURTLE_SHIFT_EN
          OP_SHL, OP_SHR: begin
            regs_d[w_ra] = w_alu_res;
            c_d          = w_alu_c;
            z_d          = w_alu_z;
          end
`endif
          OP_LD: begin
            mem_addr = w_rb_val[ADDR_W-1:0];
            state_d  = S_MEM;
          end
          OP_ST: begin
            mem_addr  = w_rb_val[ADDR_W-1:0];
            mem_wdata = w_ra_val;
            mem_we    = 1'b1;
          end
          OP_JMP: pc_d = w_jaddr;
          OP_JZ:  if (z_q) pc_d = w_jaddr;
          OP_JC:  if (c_q) pc_d = w_jaddr;
          OP_IN:  state_d = S_IN_WAIT;
          OP_OUT: begin
            out_data_d  = w_ra_val;
            out_valid_d = 1'b1;
            state_d     = S_OUT_WAIT;
          end
          OP_HALT: state_d = S_HALT;
          default: ;  // NOP, and SHL/SHR when shifts are disabled
        endcase
      end

      S_MEM: begin
        regs_d[w_ra] = mem_rdata;
        state_d      = S_FETCH;
      end

      S_IN_WAIT: begin
        // in_ready is high for the whole of this state
        if (in_valid) begin
          regs_d[w_ra] = in_data;
          state_d      = S_FETCH;
        end
      end

      S_OUT_WAIT: begin
        // out_valid is already high here; out_data is held untouched
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  assign in_ready  = (state_q == S_IN_WAIT);
  assign halted    = (state_q == S_HALT);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      ir_q        <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      regs_q      <= regs_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_turtle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_turtle_core
// Purpose  : Directed self-checking bench for turtle_core (DATA_W=16,
//            ADDR_W=10) with a synchronous RAM model. Expected SHL/SHR
//            behaviour follows TURTLE_SHIFT_EN.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_turtle_core;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] in_data   = '0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              halted;

  // RAM model controls
  logic              clr     = 1'b0;
  logic              ld_en   = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [15:0]       ld_data = '0;
  logic [15:0]       mem [1024];

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int xfer_cnt = 0;

  always #5 clk = ~clk;

  turtle_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted)
  );

  // Synchronous RAM: read data appears the cycle after the address
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'hF000;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (!rst && mem_we) we_cnt <= we_cnt + 1;
    if (!rst && out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(a);
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Put the core in reset and fill memory with HALT
  task automatic begin_test();
    rst = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_rst_we"},     mem_we,    0);
    check_eq({tag, "_rst_addr"},   mem_addr,  0);
    check_eq({tag, "_rst_wdata"},  mem_wdata, 0);
    check_eq({tag, "_rst_inrdy"},  in_ready,  0);
    check_eq({tag, "_rst_ovalid"}, out_valid, 0);
    check_eq({tag, "_rst_odata"},  out_data,  0);
    check_eq({tag, "_rst_halted"}, halted,    0);
  endtask

  task automatic wait_out(input string tag, input int bound, output logic [31:0] d);
    int k = 0;
    while (out_valid !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_out_seen"}, {31'b0, out_valid}, 1);
    d = {16'b0, out_data};
  endtask

  logic [31:0] od;
  int we0;
  int xf0;

  initial begin
    // ---- 1: LDI/LDI/ADD/HALT, halted timing ----------------------------
    begin_test();
    poke(0, 16'h12FF); poke(1, 16'h1401); poke(2, 16'h2280); poke(3, 16'hF000);
    check_reset("t1");
    rst = 1'b0;                                  // cycle 0 = first FETCH
    check_eq("t1_fetch0", mem_addr, 0);
    tick(3);  check_eq("t1_fetch1", mem_addr, 1);
    tick(8);  check_eq("t1_halt_c11", halted, 0);
    tick(1);  check_eq("t1_halt_c12", halted, 1);
    tick(5);  check_eq("t1_halt_stays", halted, 1);

    // ---- 2: ADD result and flags (r1=0x0100, C=0, Z=0) -------------------
    begin_test();
    poke(0, 16'h12FF); poke(1, 16'h1401); poke(2, 16'h2280);
    poke(3, 16'hA3F0); poke(4, 16'h93F0); poke(5, 16'hC200); poke(6, 16'hF000);
    check_reset("t2");
    out_ready = 1'b1;
    rst = 1'b0;
    tick(12); check_eq("t2_jc_not_taken", mem_addr, 4);
    tick(3);  check_eq("t2_jz_not_taken", mem_addr, 5);
    tick(3);  check_eq("t2_ovalid", out_valid, 1);
              check_eq("t2_r1", out_data, 16'h0100);
    tick(1);  check_eq("t2_next_fetch", mem_addr, 6);
    tick(3);  check_eq("t2_halted", halted, 1);

    // ---- 3: SUB r1,r1 -> Z; JZ 0x020; borrow -> JC 0x040 ---------------
    begin_test();
    poke(0, 16'h1200); poke(1, 16'h3240); poke(2, 16'h9020);
    poke(32, 16'hA030); poke(33, 16'h1401); poke(34, 16'h3280); poke(35, 16'hA040);
    poke(64, 16'hC200); poke(65, 16'hF000);
    check_reset("t3");
    rst = 1'b0;
    tick(9);  check_eq("t3_jz_taken", mem_addr, 10'h020);
    tick(3);  check_eq("t3_jc_clear", mem_addr, 10'h021);
    tick(9);  check_eq("t3_jc_borrow", mem_addr, 10'h040);
    tick(3);  check_eq("t3_ovalid", out_valid, 1);
              check_eq("t3_r1", out_data, 16'hFFFF);

    // ---- 4: IN r3, ST r3,[r4], LD r5,[r4] -------------------------------
    begin_test();
    poke(0, 16'hB600); poke(1, 16'h1805); poke(2, 16'h7700);
    poke(3, 16'h6B00); poke(4, 16'hCA00); poke(5, 16'hF000);
    check_reset("t4");
    in_data = 16'hBEEF; in_valid = 1'b1;
    we0 = we_cnt;
    rst = 1'b0;
    tick(3);  check_eq("t4_in_ready", in_ready, 1);
    tick(1);  in_valid = 1'b0;
              check_eq("t4_in_ready_drop", in_ready, 0);
              check_eq("t4_fetch1", mem_addr, 1);
    tick(5);  check_eq("t4_st_we", mem_we, 1);
              check_eq("t4_st_addr", mem_addr, 5);
              check_eq("t4_st_wdata", mem_wdata, 16'hBEEF);
    tick(1);  check_eq("t4_we_pulse", mem_we, 0);
              check_eq("t4_fetch3", mem_addr, 3);
    tick(2);  check_eq("t4_ld_addr", mem_addr, 5);
    tick(2);  check_eq("t4_ld_4cyc", mem_addr, 4);
    tick(3);  check_eq("t4_ovalid", out_valid, 1);
              check_eq("t4_r5", out_data, 16'hBEEF);
    tick(4);  check_eq("t4_we_count", we_cnt - we0, 1);
              check_eq("t4_ram5", mem[5], 16'hBEEF);

    // ---- 5: OUT with out_ready low for 5 cycles -------------------------
    begin_test();
    poke(0, 16'hB200); poke(1, 16'hC200); poke(2, 16'hF000);
    check_reset("t5");
    in_data = 16'h1234; in_valid = 1'b1; out_ready = 1'b0;
    xf0 = xfer_cnt;
    rst = 1'b0;
    tick(4);  in_valid = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_hold_valid", out_valid, 1);
      check_eq("t5_hold_data", out_data, 16'h1234);
      tick(1);
    end
    check_eq("t5_valid_c12", out_valid, 1);
    out_ready = 1'b1;                            // handshake in cycle 12
    tick(1);  out_ready = 1'b0;
              check_eq("t5_valid_drop", out_valid, 0);
              check_eq("t5_xfer_once", xfer_cnt - xf0, 1);
    tick(2);  check_eq("t5_halt_c15", halted, 0);
    tick(1);  check_eq("t5_halt_c16", halted, 1);
    tick(3);  check_eq("t5_xfer_final", xfer_cnt - xf0, 1);

    // ---- 6: reset in IN_WAIT and in OUT_WAIT ----------------------------
    begin_test();
    poke(0, 16'hC400); poke(1, 16'hB400); poke(2, 16'hF000);
    check_reset("t6");
    in_data = 16'h5555; in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    wait_out("t6a", 10, od);
    check_eq("t6_r2_initial", od, 0);
    tick(4);  check_eq("t6_in_wait", in_ready, 1);
    tick(2);  check_eq("t6_in_wait2", in_ready, 1);
    rst = 1'b1;
    tick(1);  check_eq("t6_rst_in_ready", in_ready, 0);
              check_eq("t6_rst_pc", mem_addr, 0);
    out_ready = 1'b0;
    rst = 1'b0;
    tick(3);  check_eq("t6_ovalid", out_valid, 1);
              check_eq("t6_r2_unchanged", out_data, 0);
    tick(2);  rst = 1'b1;
    tick(1);  check_eq("t6_rst_drops_valid", out_valid, 0);

    // ---- 7: SHL r1 on 0x8001 --------------------------------------------
    begin_test();
    poke(0, 16'hB200); poke(1, 16'h1401); poke(2, 16'h2480); poke(3, 16'hD200);
    poke(4, 16'hA030); poke(5, 16'hC200); poke(6, 16'hF000);
    poke(48, 16'h93F0); poke(49, 16'hC200); poke(50, 16'hF000);
    check_reset("t7");
    in_data = 16'h8001; in_valid = 1'b1; out_ready = 1'b1;
    rst = 1'b0;
    tick(4);  in_valid = 1'b0;
    tick(12);
`ifdef TURTLE_SHIFT_EN
    check_eq("t7_shl_carry", mem_addr, 10'h030);
    tick(3);  check_eq("t7_shl_nz", mem_addr, 10'h031);
    wait_out("t7", 10, od);
    check_eq("t7_shl_r1", od, 16'h0002);
`else
    check_eq("t7_nop_carry", mem_addr, 5);
    wait_out("t7", 10, od);
    check_eq("t7_nop_r1", od, 16'h8001);
`endif

    // ---- 8: PC wraps from 0x3FF to 0 ------------------------------------
    begin_test();
    poke(0, 16'h83FF); poke(1023, 16'h0000);
    check_reset("t8");
    rst = 1'b0;
    check_eq("t8_fetch0", mem_addr, 0);
    tick(3);  check_eq("t8_fetch_top", mem_addr, 10'h3FF);
    tick(3);  check_eq("t8_wrap", mem_addr, 0);
    rst = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
